// File: rtl/npc_lsu_pkg.sv
// Shared definitions for the npc load/store unit: MemOp encodings, FSM states
// and request-legality helpers.
package npc_lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic memop_legal(input logic wen, input logic [2:0] memop);
        if (wen)
            return (memop == MEMOP_B) || (memop == MEMOP_H) || (memop == MEMOP_W);
        return (memop == MEMOP_B) || (memop == MEMOP_H) || (memop == MEMOP_W) ||
               (memop == MEMOP_BU) || (memop == MEMOP_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] off);
        case (memop)
            MEMOP_H, MEMOP_HU: return off[0];
            MEMOP_W:           return off != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane logic for the LSU: store strobes and lane shift, load extract and
// sign/zero extension. Purely combinational.
module npc_lsu_align import npc_lsu_pkg::*; (
    input  logic [2:0]  memop,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [1:0]  eff_off;
    logic [4:0]  shamt;
    logic [31:0] rshift;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        eff_off    = off;
        wstrb      = 4'b0000;
        load_data  = 32'h0;

        // Misaligned halves/words are force-aligned; in the trap build they never get here.
        case (memop)
            MEMOP_H, MEMOP_HU: eff_off = {off[1], 1'b0};
            MEMOP_W:           eff_off = 2'b00;
            default:           eff_off = off;
        endcase

        shamt      = {eff_off, 3'b000};
        lane_wdata = wdata << shamt;
        rshift     = rdata >> shamt;

        case (memop)
            MEMOP_B: begin
                wstrb     = 4'b0001 << eff_off;
                load_data = {{24{rshift[7]}}, rshift[7:0]};
            end
            MEMOP_BU: begin
                wstrb     = 4'b0001 << eff_off;
                load_data = {24'h0, rshift[7:0]};
            end
            MEMOP_H: begin
                wstrb     = 4'b0011 << eff_off;
                load_data = {{16{rshift[15]}}, rshift[15:0]};
            end
            MEMOP_HU: begin
                wstrb     = 4'b0011 << eff_off;
                load_data = {16'h0, rshift[15:0]};
            end
            MEMOP_W: begin
                wstrb     = 4'b1111;
                load_data = rshift;
            end
            default: begin
                wstrb     = 4'b0000;
                load_data = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit: execute-side request -> aligned bus transaction -> writeback.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module npc_lsu import npc_lsu_pkg::*; #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_memop,
    input  logic [DW-1:0] req_wdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_wen,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    output logic [3:0]    mem_req_wstrb,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_rdata,
    input  logic          mem_rsp_err,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_misalign
);

    lsu_state_t    state;
    logic          lat_wen;
    logic [AW-1:0] lat_addr;
    logic [2:0]    lat_memop;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [3:0]    strb;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] load_data;

    npc_lsu_align u_align (
        .memop      (lat_memop),
        .off        (lat_addr[1:0]),
        .wdata      (lat_wdata),
        .rdata      (mem_rsp_rdata),
        .wstrb      (strb),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign rsp_misalign = mis_q;
`else
    assign rsp_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_memop <= 3'b000;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_wen   <= req_wen;
                    lat_addr  <= req_addr;
                    lat_memop <= req_memop;
                    lat_wdata <= req_wdata;
                    rdata_q   <= '0;
                    err_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q     <= 1'b0;
`endif
                    if (!memop_legal(req_wen, req_memop)) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (is_misaligned(req_memop, req_addr[1:0])) begin
                        err_q <= 1'b1;
                        mis_q <= 1'b1;
                        state <= DONE;
                    end
`endif
                    else begin
                        state <= REQ;
                    end
                end
                REQ: if (mem_req_ready) state <= WAIT;
                // Stores complete on the write ack and return zero data.
                WAIT: if (mem_rsp_valid) begin
                    rdata_q <= lat_wen ? '0 : load_data;
                    err_q   <= mem_rsp_err;
                    state   <= DONE;
                end
                DONE: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_req_wen   = lat_wen;
    assign mem_req_addr  = {lat_addr[AW-1:2], 2'b00};
    assign mem_req_wdata = lane_wdata;
    assign mem_req_wstrb = lat_wen ? strb : 4'b0000;
    assign rsp_valid     = (state == DONE);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;

endmodule

// File: doc/npc_lsu.md
Name: npc_lsu

Overview:
- Multi-cycle load/store unit between the execute stage (ALU result, rs2, MemOp, read/write enables) and the data-memory bus port.
- Replaces direct DPI data access: converts a byte/half/word request into a word-aligned bus transaction with byte strobes.
- Waits for the bus response, then returns sign/zero-extended load data (or a store ack) to writeback over valid/ready.

Parameters:
- AW, 32, address width
- DW, 32, data width; fixed at 32, strobe width DW/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  execute-side request valid
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  AW  byte address (ALU result)
- req_memop  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  DW  store data (rs2)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  bus write
- mem_req_addr  out  AW  word-aligned address, low 2 bits = 0
- mem_req_wdata  out  DW  store data shifted into lane
- mem_req_wstrb  out  4  byte strobes; 0000 on loads
- mem_rsp_valid  in  1  bus response or write ack
- mem_rsp_rdata  in  DW  raw aligned word
- mem_rsp_err  in  1  bus error
- rsp_valid  out  1  result valid to writeback
- rsp_ready  in  1  writeback accepts result
- rsp_rdata  out  DW  extended load data; 0 for stores
- rsp_err  out  1  access failed: bus error, illegal op, or misalign trap
- rsp_misalign  out  1  misaligned access trapped (see feature)

Behaviour:
- FSM states IDLE, REQ, WAIT, DONE. All outputs are decoded from registered state/data.
- Reset: rst_n low at a rising edge forces IDLE and clears the latched request, rsp_rdata, rsp_err and rsp_misalign.
  - After reset: req_ready=1; mem_req_valid, mem_req_wen, mem_req_wstrb, rsp_valid, rsp_err, rsp_misalign = 0; data outputs = 0.
- IDLE: req_ready=1. When req_valid=1, latch wen/addr/memop/wdata.
  - Legal request: go to REQ.
  - Illegal memop (store with memop not in {000,001,010}; load with memop in {011,110,111}): go to DONE with rsp_err=1 and no bus access.
- REQ: mem_req_valid=1, bus fields held stable until mem_req_ready=1, then go to WAIT. Bus ready may stall indefinitely.
- WAIT: mem_req_valid=0. On mem_rsp_valid, capture the extended data (loads) and mem_rsp_err, then go to DONE.
  - Stores also wait for mem_rsp_valid (write ack).
- DONE: rsp_valid=1, outputs held until rsp_ready=1, then go to IDLE. No new request is accepted in the same cycle (req_ready=0 in DONE).
- Latency with zero bus wait: request accepted at edge 0, REQ in cycle 1 (handshake), WAIT in cycle 2 with mem_rsp_valid, rsp_valid in cycle 3.
- Alignment logic, with off = addr[1:0]:
  - Strobes: B/BU 0001<<off; H/HU 0011<<off; W 1111.
  - mem_req_wdata = wdata << (8*off).
  - Load: shift rdata >> (8*off), take 8/16/32 bits, sign-extend for 000/001, zero-extend for 100/101.
- Misaligned access: H with off[0]=1, or W with off≠0. Handling depends on the optional feature below.
- A mem_rsp_valid seen in IDLE, REQ or DONE is ignored.
- Reset mid-transaction (REQ/WAIT) abandons it; mem_req_valid drops the cycle after the reset edge. A late response is ignored.
- Address arithmetic wraps modulo 2^AW; no carry into any other field.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined: a misaligned request performs no bus access; the FSM goes IDLE→DONE with rsp_err=1, rsp_misalign=1, rsp_rdata=0.
- Undefined: the address is force-aligned (H clears bit 0, W clears bits 1:0) and the access proceeds normally; rsp_misalign is tied to 0.

Decomposition:
- Shared package npc_lsu_pkg holds:
  - MemOp encodings MEMOP_B/H/W/BU/HU
  - FSM state enum lsu_state_t (IDLE, REQ, WAIT, DONE)
  - a misalign-check function
- MemOp constants replace the ad-hoc literals in the existing memory path.
- One combinational sub-module, npc_lsu_align: strobe generation, store lane shift, load extract and extend. The FSM stays in npc_lsu.

Test Plan:
- SB addr 0x8000_0003, wdata 0x1234_56AB → mem_req_addr 0x8000_0000, wstrb 1000, wdata 0xAB00_0000; ack → rsp_valid, rsp_err=0, rsp_rdata=0.
- LB addr 0x8000_0001, rsp_rdata 0x0000_8000 → rsp_rdata 0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH addr 0x8000_0002, mem_req_ready low for 5 cycles, rsp 0x8001_0000 → bus fields stable throughout; rsp_rdata 0xFFFF_8001.
- LW addr 0x8000_0002:
  - with macro → no mem_req_valid; rsp_err=1, rsp_misalign=1 within 1 cycle.
  - without → bus addr 0x8000_0000, normal completion.
- Store with memop 100 → no bus access, rsp_err=1. LW with mem_rsp_err=1 → rsp_err=1.
- rst_n low while in WAIT, then mem_rsp_valid arrives → IDLE, rsp_valid stays 0, req_ready=1. A held rsp_ready=0 in DONE keeps rsp_valid and rsp_rdata unchanged.
